alu_sequencer: RTL and testbench

//  Sequences the 8-bit ALU for the processor control path. Accepts one operation per

---
 rtl/alu_sequencer_if.sv | 26 ++
 rtl/alu_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Requester-side bus of the ALU sequencer: the operation handshake going in and
// the completion/result signals coming back.
interface alu_sequencer_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] opcode;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       done;
   logic       err;
   logic       res_negative;
   logic [3:0] res_left;
   logic [3:0] res_right;

   // Requester side: issues operations, observes completion.
   modport master (
      output instr_valid, opcode, op_a, op_b,
      input  instr_ready, done, err, res_negative, res_left, res_right
   );

   // Sequencer side: accepts operations, reports completion.
   modport slave (
      input  instr_valid, opcode, op_a, op_b,
      output instr_ready, done, err, res_negative, res_left, res_right
   );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one operation per handshake, drives the one-hot
// selector to the ALU for EXEC_CYCLES clocks, captures the ALU result and
// pulses done. Illegal opcodes complete immediately with err and no ALU op.
module alu_sequencer #(
   parameter int EXEC_CYCLES = 2,
   parameter int NUM_OPS     = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_sequencer_if.slave req,
   output logic [7:0]  o_alu_a,
   output logic [7:0]  o_alu_b,
   output logic [15:0] o_alu_selector,
   input  logic        i_alu_negative,
   input  logic [3:0]  i_alu_left,
   input  logic [3:0]  i_alu_right,
   output logic [7:0]  o_op_count
);

   // Counter only has to hold EXEC_CYCLES-1; keep at least one bit.
   localparam int            CW       = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);
   localparam logic [4:0]    OPS_LIM  = 5'(NUM_OPS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_CAPT = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t        r_state;
   logic          r_ready;
   logic          r_done;
   logic          r_err;
   logic [15:0]   r_sel;
   logic [7:0]    r_a;
   logic [7:0]    r_b;
   logic [CW-1:0] r_cnt;
   logic          r_res_negative;
   logic [3:0]    r_res_left;
   logic [3:0]    r_res_right;
   logic [7:0]    r_op_count;

   logic          w_legal;
   logic [15:0]   w_sel;

   // Opcode decode: legality range check and one-hot selector.
   assign w_legal = ({1'b0, req.opcode} < OPS_LIM);
   assign w_sel   = 16'h0001 << req.opcode;

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_ready        <= 1'b1;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_sel          <= '0;
         r_a            <= '0;
         r_b            <= '0;
         r_cnt          <= '0;
         r_res_negative <= 1'b0;
         r_res_left     <= '0;
         r_res_right    <= '0;
         r_op_count     <= '0;
      end else begin
         // done/err are single-cycle pulses unless re-asserted below.
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req.instr_valid) begin
                  r_ready <= 1'b0;
                  if (w_legal) begin
                     r_a     <= req.op_a;
                     r_b     <= req.op_b;
                     r_sel   <= w_sel;
                     r_cnt   <= CNT_LOAD;
                     r_state <= S_EXEC;
                  end else begin
                     // Rejected: no ALU op, operands and selector untouched.
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                     r_state <= S_ERR;
                  end
               end
            end
            S_EXEC: begin
               if (r_cnt == '0) begin
                  r_res_negative <= i_alu_negative;
                  r_res_left     <= i_alu_left;
                  r_res_right    <= i_alu_right;
                  r_sel          <= '0;
                  r_done         <= 1'b1;
                  r_op_count     <= r_op_count + 8'd1;
                  r_state        <= S_CAPT;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_CAPT, S_ERR: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_ready <= 1'b1;
               r_sel   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req.instr_ready  = r_ready;
   assign req.done         = r_done;
   assign req.err          = r_err;
   assign req.res_negative = r_res_negative;
   assign req.res_left     = r_res_left;
   assign req.res_right    = r_res_right;
   assign o_alu_a          = r_a;
   assign o_alu_b          = r_b;
   assign o_alu_selector   = r_sel;
   assign o_op_count       = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table, back-to-back run,
// asynchronous reset mid-operation, and a randomized run through op_count wrap.
module tb_alu_sequencer;

   localparam int EXEC_CYCLES = 2;
   localparam int NUM_OPS     = 9;

   logic        clk;
   logic        rst_n;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [15:0] alu_selector;
   logic        alu_negative;
   logic [3:0]  alu_left;
   logic [3:0]  alu_right;
   logic [7:0]  op_count;

   alu_sequencer_if bus ();

   alu_sequencer #(
      .EXEC_CYCLES (EXEC_CYCLES),
      .NUM_OPS     (NUM_OPS)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req            (bus),
      .o_alu_a        (alu_a),
      .o_alu_b        (alu_b),
      .o_alu_selector (alu_selector),
      .i_alu_negative (alu_negative),
      .i_alu_left     (alu_left),
      .i_alu_right    (alu_right),
      .o_op_count     (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state, derived from the behavioural rules only.
   int         m_count;
   logic [7:0] m_a, m_b;
   logic       m_neg;
   logic [3:0] m_left, m_right;

   typedef struct {
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic        n;
      logic [3:0]  l;
      logic [3:0]  r;
      logic [15:0] exp_sel;
      bit          exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_count = 0; m_a = '0; m_b = '0; m_neg = 1'b0; m_left = '0; m_right = '0;
   endfunction

   // Busy-time garbage on the request bus; must not be sampled.
   task automatic scramble_req(input bit hold);
      bus.instr_valid = hold;
      bus.opcode      = 4'($urandom_range(0, 15));
      bus.op_a        = 8'($urandom);
      bus.op_b        = 8'($urandom);
   endtask

   // One full transaction starting from an idle negedge.
   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic n, input logic [3:0] l, input logic [3:0] r,
                         input logic [15:0] exp_sel, input bit exp_err, input bit hold);
      chk("ready_idle", 32'(bus.instr_ready), 32'd1);
      bus.instr_valid = 1'b1;
      bus.opcode      = op;
      bus.op_a        = a;
      bus.op_b        = b;
      // ALU lines differ from the true result except right before capture.
      alu_negative = ~n; alu_left = ~l; alu_right = ~r;
      @(posedge clk);
      @(negedge clk);
      scramble_req(hold);
      if (!exp_err) begin
         m_a = a; m_b = b;
         for (int c = 0; c < EXEC_CYCLES; c++) begin
            chk("sel_exec", 32'(alu_selector), 32'(exp_sel));
            chk("alu_a_exec", 32'(alu_a), 32'(m_a));
            chk("alu_b_exec", 32'(alu_b), 32'(m_b));
            chk("done_exec", 32'(bus.done), 32'd0);
            chk("ready_exec", 32'(bus.instr_ready), 32'd0);
            if (c == EXEC_CYCLES - 1) begin
               alu_negative = n; alu_left = l; alu_right = r;
            end
            @(posedge clk);
            @(negedge clk);
            scramble_req(hold);
         end
         m_count = (m_count + 1) % 256;
         m_neg = n; m_left = l; m_right = r;
         alu_negative = ~n; alu_left = ~l; alu_right = ~r;
         chk("done_capt", 32'(bus.done), 32'd1);
         chk("err_capt", 32'(bus.err), 32'd0);
         chk("sel_capt", 32'(alu_selector), 32'd0);
      end else begin
         chk("done_err", 32'(bus.done), 32'd1);
         chk("err_err", 32'(bus.err), 32'd1);
         chk("sel_err", 32'(alu_selector), 32'd0);
         chk("alu_a_err", 32'(alu_a), 32'(m_a));
         chk("alu_b_err", 32'(alu_b), 32'(m_b));
      end
      chk("ready_busy", 32'(bus.instr_ready), 32'd0);
      chk("res_neg", 32'(bus.res_negative), 32'(m_neg));
      chk("res_left", 32'(bus.res_left), 32'(m_left));
      chk("res_right", 32'(bus.res_right), 32'(m_right));
      chk("op_count", 32'(op_count), 32'(m_count));
      @(posedge clk);
      @(negedge clk);
      chk("done_after", 32'(bus.done), 32'd0);
      chk("err_after", 32'(bus.err), 32'd0);
      chk("ready_after", 32'(bus.instr_ready), 32'd1);
      $display("op=%0d a=%02h b=%02h err=%0b res=%0b/%0h/%0h count=%0d",
               op, a, b, exp_err, bus.res_negative, bus.res_left, bus.res_right, op_count);
   endtask

   vec_t table_v[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  rop;
      logic [15:0] rsel;
      bit          rerr;
      int          legal_done;

      table_v = '{
         '{4'd0,  8'h59, 8'h72, 1'b0, 4'h1, 4'h2, 16'h0001, 1'b0},
         '{4'd12, 8'hAA, 8'h55, 1'b0, 4'h0, 4'h0, 16'h0000, 1'b1},
         '{4'd7,  8'h01, 8'hFE, 1'b1, 4'h3, 4'h9, 16'h0080, 1'b0},
         '{4'd9,  8'h33, 8'h44, 1'b0, 4'h0, 4'h0, 16'h0000, 1'b1},
         '{4'd8,  8'hFF, 8'h00, 1'b0, 4'hC, 4'h5, 16'h0100, 1'b0},
         '{4'd15, 8'h10, 8'h20, 1'b0, 4'h0, 4'h0, 16'h0000, 1'b1}
      };

      rst_n = 1'b0;
      bus.instr_valid = 1'b0; bus.opcode = '0; bus.op_a = '0; bus.op_b = '0;
      alu_negative = 1'b0; alu_left = '0; alu_right = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus.instr_ready), 32'd1);
      chk("rst_sel", 32'(alu_selector), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_count", 32'(op_count), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table (includes ERR holding a captured result).
      foreach (table_v[i])
         run_op(table_v[i].op, table_v[i].a, table_v[i].b, table_v[i].n,
                table_v[i].l, table_v[i].r, table_v[i].exp_sel, table_v[i].exp_err, 1'b0);

      // Back-to-back opcodes 0..8 with valid held high.
      for (int k = 0; k < NUM_OPS; k++)
         run_op(4'(k), 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                16'h0001 << k, 1'b0, 1'b1);
      bus.instr_valid = 1'b0;
      chk("count_b2b", 32'(op_count), 32'(6 % 256 == 6 ? 3 + NUM_OPS : 0));

      // Asynchronous reset in the middle of EXEC.
      bus.instr_valid = 1'b1; bus.opcode = 4'd5; bus.op_a = 8'hC3; bus.op_b = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      chk("sel_pre_rst", 32'(alu_selector), 32'h0020);
      #2 rst_n = 1'b0;
      #1;
      chk("async_sel", 32'(alu_selector), 32'd0);
      chk("async_ready", 32'(bus.instr_ready), 32'd1);
      chk("async_count", 32'(op_count), 32'd0);
      chk("async_alu_a", 32'(alu_a), 32'd0);
      chk("async_res_left", 32'(bus.res_left), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < EXEC_CYCLES + 2; k++) begin
         @(negedge clk);
         chk("post_rst_done", 32'(bus.done), 32'd0);
         chk("post_rst_ready", 32'(bus.instr_ready), 32'd1);
      end

      // Random traffic until 256 legal ops completed since reset.
      legal_done = 0;
      while (legal_done < 256) begin
         rop  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(NUM_OPS, 15))
                                            : 4'($urandom_range(0, NUM_OPS - 1));
         rerr = (int'(rop) >= NUM_OPS);
         rsel = rerr ? 16'h0000 : (16'h0001 << rop);
         run_op(rop, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                rsel, rerr, 1'($urandom));
         bus.instr_valid = 1'b0;
         if (!rerr) legal_done++;
      end
      chk("count_wrap", 32'(op_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
